// File: rtl/decoder_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : decoder_rr_arbiter
// Brief   : Round-robin arbiter with registered one-hot grant and binary index
//           for a shared decoder-addressed resource. Optional forced release
//           after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decoder_rr_arbiter #(
  parameter int n        = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2**n-1:0]   req,
  input  logic              done,
  output logic [2**n-1:0]   gnt,
  output logic [n-1:0]      gnt_idx,
  output logic              busy,
  output logic              timeout
);

  localparam int         c_NREQ  = 2**n;
  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [c_NREQ-1:0] gnt_q, gnt_d;
  logic [n-1:0]      gnt_idx_q, gnt_idx_d;
  logic [n-1:0]      last_q, last_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic              w_pick_found;
  logic [n-1:0]      w_pick_idx;
  logic              w_release;
  logic              w_expire;

  // Scan last+1, last+2, ... ; n-bit addition provides the modulo wrap.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = last_q;
    for (int k = 1; k <= c_NREQ; k++) begin
      logic [n-1:0] cand;
      cand = last_q + n'(k);
      if (!w_pick_found && req[cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = cand;
      end
    end
  end

  assign w_release = done | ~req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam int            c_CW   = $clog2(MAX_HOLD + 1);
  localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_HOLD);
  localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

  logic [c_CW-1:0] hold_q, hold_d;

  // hold_q counts cycles the current grant has been visible.
  always_comb begin
    hold_d = hold_q;
    if (state_q == c_IDLE) begin
      if (en && w_pick_found) hold_d = c_ONE;
    end else if (!w_release && !w_expire) begin
      hold_d = hold_q + c_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  assign w_expire = (state_q == c_GRANT) && (hold_q == c_MAX);
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= c_IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      last_q    <= '1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (en && w_pick_found)     state_d = c_GRANT;
      c_GRANT: if (w_release || w_expire)  state_d = c_IDLE;
      default:                             state_d = c_IDLE;
    endcase
  end

  // A normal release outranks the forced one, so timeout only fires alone.
  always_comb begin
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      c_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (en && w_pick_found) begin
          gnt_d[w_pick_idx] = 1'b1;
          gnt_idx_d         = w_pick_idx;
          last_d            = w_pick_idx;
          busy_d            = 1'b1;
        end
      end
      c_GRANT: begin
        if (w_release) begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end else if (w_expire) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_decoder_rr_arbiter
// Brief   : Scoreboard bench for decoder_rr_arbiter (n=2, MAX_HOLD=4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decoder_rr_arbiter;

  localparam int NSEL = 2;
  localparam int NREQ = 4;
  localparam int MAXH = 4;

  logic            clk;
  logic            rst;
  logic            en;
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [NSEL-1:0] gnt_idx;
  logic            busy;
  logic            timeout;

  decoder_rr_arbiter #(.n(NSEL), .MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [NSEL-1:0] idx;
    logic            busy;
    logic            to;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who owns the resource, who was served last, how long held.
  int m_busy, m_owner, m_last, m_hold, m_to;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_hold = 0; m_to = 0;
    end else begin
      exp_t e;
      int   c;
      m_to = 0;
      if (m_busy != 0) begin
        if (done || !req[m_owner]) m_busy = 0;
`ifdef ARB_TIMEOUT_EN
        else if (m_hold >= MAXH) begin m_busy = 0; m_to = 1; end
`endif
        else m_hold++;
      end else if (en && req != 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (req[c]) begin m_owner = c; break; end
        end
        m_busy = 1; m_last = m_owner; m_hold = 1;
      end
      e.gnt  = (m_busy != 0) ? (NREQ'(1) << m_owner) : '0;
      e.idx  = NSEL'(m_owner);
      e.busy = (m_busy != 0);
      e.to   = (m_to != 0);
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("rst_gnt",  32'(gnt),     0);
      chk("rst_busy", 32'(busy),    0);
      chk("rst_to",   32'(timeout), 0);
      chk("rst_idx",  32'(gnt_idx), 0);
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt",     32'(gnt),     32'(e.gnt));
      chk("gnt_idx", 32'(gnt_idx), 32'(e.idx));
      chk("busy",    32'(busy),    32'(e.busy));
      chk("timeout", 32'(timeout), 32'(e.to));
      chk("onehot0", 32'($onehot0(gnt)), 1);
      chk("gnt_at_idx", 32'(gnt[gnt_idx]), 32'(busy));
    end
  end

  task automatic cyc(input logic e, input logic [NREQ-1:0] r, input logic d);
    en = e; req = r; done = d;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; done = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Single request, then done pulse
    cyc(1, 4'b0100, 0);
    cyc(1, 4'b0100, 1);
    cyc(1, 4'b0000, 0);
    cyc(1, 4'b0000, 1);

    // Fairness with all requesting, done pulsed during each grant
    for (int i = 0; i < 12; i++) cyc(1, 4'b1111, busy);

    // Wrap and skip, then owner drops request without done
    cyc(1, 4'b1000, 0);
    cyc(1, 4'b1000, 0);
    cyc(1, 4'b1000, 1);
    cyc(1, 4'b0011, 0);
    cyc(1, 4'b0011, 1);
    cyc(1, 4'b0011, 0);
    cyc(1, 4'b0011, 0);
    cyc(1, 4'b0001, 0);
    cyc(1, 4'b0000, 0);

    // Enable gating
    for (int i = 0; i < 5; i++) cyc(0, 4'b1000, 0);
    cyc(1, 4'b1000, 0);
    cyc(0, 4'b1000, 0);
    cyc(0, 4'b1000, 1);
    cyc(1, 4'b0000, 0);

    // Hold without done: forced release only with the timeout feature
    for (int i = 0; i < 25; i++) cyc(1, 4'b0011, 0);
    cyc(1, 4'b0000, 0);

    // Async reset while requester 2 owns the resource
    cyc(1, 4'b0100, 0);
    cyc(1, 4'b0100, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gnt",  32'(gnt),     0);
    chk("async_rst_busy", 32'(busy),    0);
    chk("async_rst_to",   32'(timeout), 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 4'b1111, 0);
    cyc(1, 4'b1111, 1);
    cyc(1, 4'b0000, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [NREQ-1:0] r;
      int              len;
      r   = NREQ'($urandom);
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++)
        cyc(($urandom % 8) != 0, r, ($urandom % 4) == 0);
    end

    cyc(1, 4'b0000, 0);
    cyc(1, 4'b0000, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
